// File: rtl/cpu_data_responder.sv
// Memory-side responder for the CPU data bus: word RAM, cycle counter, output FIFO and status register.
// Optional feature macro: RESPONDER_CYCLE_COUNTER_EN enables the CYCLE register at 0xFF00.
module cpu_data_responder #(
   parameter int RAM_WORDS  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [15:0] i_address,
   input  logic        i_rw,
   input  logic [31:0] i_data,
   output logic [31:0] o_data,
   output logic        o_out_valid,
   output logic [31:0] o_out_data,
   input  logic        i_out_ready,
   output logic        o_fault
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int FW = $clog2(FIFO_DEPTH);

   logic [13:0]   word_addr;
   logic [31:0]   addr32;
   logic          cyc_hit, out_hit, stat_hit, ram_hit, unmapped;
   logic [AW-1:0] ram_idx;

   assign word_addr = i_address[15:2];
   assign addr32    = {16'b0, i_address};
   assign cyc_hit   = (word_addr == 14'h3FC0);
   assign out_hit   = (word_addr == 14'h3FC1);
   assign stat_hit  = (word_addr == 14'h3FC2);
   // Registers take priority so a maximal RAM cannot shadow them.
   assign ram_hit   = !(cyc_hit || out_hit || stat_hit) && (addr32 < 32'(RAM_WORDS * 4));
   assign unmapped  = !(cyc_hit || out_hit || stat_hit || ram_hit);
   assign ram_idx   = i_address[AW+1:2];

   // RAM: no reset, write at the edge, asynchronous read
   logic [31:0] mem [RAM_WORDS];
   always_ff @(posedge i_clk) begin
      if (i_rw && ram_hit) mem[ram_idx] <= i_data;
   end

   // Output FIFO
   logic [31:0] fifo_mem [FIFO_DEPTH];
   logic [FW-1:0] rd_ptr, wr_ptr;
   logic [FW:0]   count;
   logic          full, empty, pop, push_req, push_ok;
   logic          overflow, fault;

   assign full     = (count == (FW+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign pop      = !empty && i_out_ready;
   assign push_req = i_rw && out_hit;
   assign push_ok  = push_req && (!full || pop);

   always_ff @(posedge i_clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         fault    <= 1'b0;
      end else begin
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (!push_ok && pop) count <= count - 1'b1;
         // Set terms are ORed after the clear so a same-cycle event wins.
         overflow <= (overflow && !(i_rw && stat_hit && i_data[2])) || (push_req && full && !pop);
         fault    <= (fault && !(i_rw && stat_hit && i_data[3])) || (i_rw && unmapped);
      end
   end

   logic [31:0] cycle_val;
`ifdef RESPONDER_CYCLE_COUNTER_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)           cycle_val <= '0;
      else if (i_rw && cyc_hit) cycle_val <= i_data;
      else                      cycle_val <= cycle_val + 32'd1;
   end
`else
   assign cycle_val = '0;
`endif

   logic [31:0] status;
   assign status = {23'b0, 5'(count), fault, overflow, empty, full};

   always_comb begin
      o_data = '0;
      if (ram_hit)       o_data = mem[ram_idx];
      else if (cyc_hit)  o_data = cycle_val;
      else if (stat_hit) o_data = status;
   end

   assign o_out_valid = !empty;
   assign o_out_data  = empty ? 32'd0 : fifo_mem[rd_ptr];
   assign o_fault     = fault;

endmodule
